// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding 64-bit memory access with byte-lane steering and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests complete with an error instead of accessing memory.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [63:0] ALUResult,
    input  logic [63:0] ReadData2,
    output logic        resp_valid,
    output logic [63:0] ReadData,
    output logic        misaligned,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    typedef struct packed {
        logic       store;
        logic [2:0] funct3;
        logic [2:0] lane;
    } op_t;

    state_t      state;
    op_t         op;
    logic [7:0]  strb_base;
    logic [63:0] shifted;
    logic [63:0] load_val;

    always_comb begin
        strb_base = 8'h01;
        case (funct3[1:0])
            2'd0: strb_base = 8'h01;
            2'd1: strb_base = 8'h03;
            2'd2: strb_base = 8'h0F;
            2'd3: strb_base = 8'hFF;
            default: strb_base = 8'h01;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_in;
    logic mis_q;

    always_comb begin
        mis_in = 1'b0;
        case (funct3[1:0])
            2'd0: mis_in = 1'b0;
            2'd1: mis_in = ALUResult[0];
            2'd2: mis_in = |ALUResult[1:0];
            2'd3: mis_in = |ALUResult[2:0];
            default: mis_in = 1'b0;
        endcase
        if (funct3 == 3'b111)
            mis_in = 1'b1;
    end

    assign misaligned = mis_q;
`else
    assign misaligned = 1'b0;
`endif

    // Bring the addressed lane down to bit 0, then narrow and extend.
    always_comb begin
        shifted  = mem_rdata >> {op.lane, 3'b000};
        load_val = shifted;
        case (op.funct3)
            3'b000: load_val = {{56{shifted[7]}},  shifted[7:0]};
            3'b001: load_val = {{48{shifted[15]}}, shifted[15:0]};
            3'b010: load_val = {{32{shifted[31]}}, shifted[31:0]};
            3'b100: load_val = {56'd0, shifted[7:0]};
            3'b101: load_val = {48'd0, shifted[15:0]};
            3'b110: load_val = {32'd0, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op         <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            ReadData   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op        <= {MemWrite, funct3, ALUResult[2:0]};
                        if (!MemRead && !MemWrite) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end
`ifdef LSU_MISALIGN_TRAP_EN
                        else if (mis_in) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            mis_q      <= 1'b1;
                        end
`endif
                        else begin
                            // Lanes pushed past byte 7 fall off the top of the shift.
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= {ALUResult[63:3], 3'b000};
                            mem_wdata <= MemWrite ? (ReadData2 << {ALUResult[2:0], 3'b000}) : '0;
                            mem_wstrb <= MemWrite ? (strb_base << ALUResult[2:0]) : '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (op.store) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        ReadData   <= load_val;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_q      <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; expected values are hand-derived per vector.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [63:0] ALUResult;
    logic [63:0] ReadData2;
    logic        resp_valid;
    logic [63:0] ReadData;
    logic        misaligned;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .ALUResult(ALUResult), .ReadData2(ReadData2),
        .resp_valid(resp_valid), .ReadData(ReadData), .misaligned(misaligned),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one cycle after acceptance (REQ, or RESP for no-op/error).
    task automatic send(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] d);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        if (!req_ready)
            chk("ready_timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b1; MemRead = rd; MemWrite = wr;
        funct3 = f3; ALUResult = a; ReadData2 = d;
        step();
        req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    // From REQ with grant held: into WAIT, return data, land in RESP.
    task automatic load_rsp(input logic [63:0] rdata);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = '0; ALUResult = '0; ReadData2 = '0;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

        #12;
        chk("rst_req_ready",  64'(req_ready),  64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mem_req",    64'(mem_req),    64'd0);
        chk("rst_mem_wstrb",  64'(mem_wstrb),  64'd0);
        chk("rst_mem_addr",   mem_addr,        64'd0);
        chk("rst_readdata",   ReadData,        64'd0);
        @(negedge clk) reset = 1'b1;
        step();
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        // SD at 0x10, grant held: resp in cycle 2
        send(1'b0, 1'b1, 3'b011, 64'h10, 64'h1122334455667788);
        chk("sd_mem_req",  64'(mem_req),   64'd1);
        chk("sd_mem_we",   64'(mem_we),    64'd1);
        chk("sd_addr",     mem_addr,       64'h10);
        chk("sd_wstrb",    64'(mem_wstrb), 64'hFF);
        chk("sd_wdata",    mem_wdata,      64'h1122334455667788);
        chk("sd_ready_c1", 64'(req_ready), 64'd0);
        chk("sd_resp_c1",  64'(resp_valid), 64'd0);
        step();
        chk("sd_resp_c2",  64'(resp_valid), 64'd1);
        chk("sd_mis",      64'(misaligned), 64'd0);
        step();
        chk("sd_resp_c3",  64'(resp_valid), 64'd0);
        chk("sd_ready_c3", 64'(req_ready),  64'd1);

        // LB / LBU at 0x23: byte 3 of the doubleword is 0x80
        send(1'b1, 1'b0, 3'b000, 64'h23, 64'd0);
        chk("lb_addr",  mem_addr,       64'h20);
        chk("lb_we",    64'(mem_we),    64'd0);
        chk("lb_wstrb", 64'(mem_wstrb), 64'd0);
        load_rsp(64'h0000000080000000);
        chk("lb_resp_c3", 64'(resp_valid), 64'd1);
        chk("lb_data",    ReadData,        64'hFFFFFFFFFFFFFF80);
        step();
        send(1'b1, 1'b0, 3'b100, 64'h23, 64'd0);
        load_rsp(64'h0000000080000000);
        chk("lbu_data", ReadData, 64'h80);
        step();

        // SH at 0x06 lands in the top two lanes
        send(1'b0, 1'b1, 3'b001, 64'h06, 64'hABCD);
        chk("sh_wstrb", 64'(mem_wstrb), 64'hC0);
        chk("sh_wdata", mem_wdata,      64'hABCD000000000000);
        step();
        step();

        // SW at 0x04 with grant withheld for 5 cycles
        mem_gnt = 1'b0;
        send(1'b0, 1'b1, 3'b010, 64'h04, 64'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_req_%0d", i),   64'(mem_req),   64'd1);
            chk($sformatf("stall_addr_%0d", i),  mem_addr,       64'h0);
            chk($sformatf("stall_wstrb_%0d", i), 64'(mem_wstrb), 64'hF0);
            chk($sformatf("stall_wdata_%0d", i), mem_wdata,      64'hDEADBEEF00000000);
            chk($sformatf("stall_ready_%0d", i), 64'(req_ready), 64'd0);
            step();
        end
        mem_gnt = 1'b1;
        step();
        chk("stall_resp",     64'(resp_valid), 64'd1);
        chk("store_hold_rd",  ReadData,        64'h80);
        step();

        // no-op completes without memory traffic, ReadData untouched
        send(1'b0, 1'b0, 3'b011, 64'h40, 64'd0);
        chk("noop_mem_req", 64'(mem_req),    64'd0);
        chk("noop_resp",    64'(resp_valid), 64'd1);
        chk("noop_hold_rd", ReadData,        64'h80);
        step();

        // LHU at 0x0A and LD at 0x18
        send(1'b1, 1'b0, 3'b101, 64'h0A, 64'd0);
        load_rsp(64'h123456789ABC0000);
        chk("lhu_data", ReadData, 64'h9ABC);
        step();
        send(1'b1, 1'b0, 3'b011, 64'h18, 64'd0);
        load_rsp(64'h0123456789ABCDEF);
        chk("ld_data", ReadData, 64'h0123456789ABCDEF);
        step();

`ifdef LSU_MISALIGN_TRAP_EN
        send(1'b1, 1'b0, 3'b010, 64'h02, 64'd0);
        chk("lw02_mem_req", 64'(mem_req),    64'd0);
        chk("lw02_resp",    64'(resp_valid), 64'd1);
        chk("lw02_mis",     64'(misaligned), 64'd1);
        chk("lw02_hold_rd", ReadData,        64'h0123456789ABCDEF);
        step();
        chk("lw02_mis_clr", 64'(misaligned), 64'd0);
        send(1'b0, 1'b1, 3'b010, 64'h06, 64'hDEADBEEF);
        chk("sw06_mem_req", 64'(mem_req),    64'd0);
        chk("sw06_mis",     64'(misaligned), 64'd1);
        step();
`else
        send(1'b1, 1'b0, 3'b010, 64'h02, 64'd0);
        chk("lw02_mem_req", 64'(mem_req),   64'd1);
        chk("lw02_wstrb",   64'(mem_wstrb), 64'd0);
        chk("lw02_addr",    mem_addr,       64'h0);
        load_rsp(64'h0000876543210000);
        chk("lw02_mis",  64'(misaligned), 64'd0);
        chk("lw02_data", ReadData,        64'hFFFFFFFF87654321);
        step();
        send(1'b0, 1'b1, 3'b010, 64'h06, 64'hDEADBEEF);
        chk("sw06_wstrb", 64'(mem_wstrb), 64'hC0);
        chk("sw06_wdata", mem_wdata,      64'hBEEF000000000000);
        step();
        chk("sw06_resp",  64'(resp_valid), 64'd1);
        step();
`endif

        // reset while stalled in REQ drops mem_req immediately
        mem_gnt = 1'b0;
        send(1'b1, 1'b0, 3'b011, 64'h30, 64'd0);
        chk("rreq_mem_req_pre", 64'(mem_req), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("rreq_mem_req", 64'(mem_req), 64'd0);
        chk("rreq_addr",    mem_addr,      64'h0);
        @(negedge clk) reset = 1'b1;
        mem_gnt = 1'b1;
        step();
        chk("rreq_ready", 64'(req_ready), 64'd1);

        // reset while in WAIT; a late mem_rvalid must be ignored
        send(1'b1, 1'b0, 3'b000, 64'h00, 64'd0);
        step();
        #2 reset = 1'b0;
        #1;
        chk("rwait_mem_req", 64'(mem_req),    64'd0);
        chk("rwait_resp",    64'(resp_valid), 64'd0);
        chk("rwait_ready",   64'(req_ready),  64'd0);
        chk("rwait_rd",      ReadData,        64'd0);
        @(negedge clk) reset = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFFFFFFFFFFFFFF;
        step();
        chk("stray_resp_0", 64'(resp_valid), 64'd0);
        mem_rvalid = 1'b0;
        step();
        chk("stray_resp_1", 64'(resp_valid), 64'd0);
        chk("stray_rd",     ReadData,        64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; low clears all state immediately, release sampled on clk.
REQ-003 req_valid  input  1  core presents a memory operation.
REQ-004 req_ready  output  1  LSU can accept a request (high only in IDLE).
REQ-005 MemRead  input  1  request is a load.
REQ-006 MemWrite  input  1  request is a store; wins over MemRead if both are high.
REQ-007 funct3  input  3  size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU, 111 illegal.
REQ-008 ALUResult  input  64  byte address.
REQ-009 ReadData2  input  64  store data, right-justified.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 ReadData  output  64  aligned, extended load result; valid with resp_valid.
REQ-012 misaligned  output  1  error flag qualified by resp_valid.
REQ-013 mem_req  output  1  request to data memory.
REQ-014 mem_gnt  input  1  memory accepts the request.
REQ-015 mem_we  output  1  store when high.
REQ-016 mem_addr  output  64  ALUResult with bits [2:0] cleared.
REQ-017 mem_wdata  output  64  store data shifted into its byte lane.
REQ-018 mem_wstrb  output  8  byte enables; all zero for loads.
REQ-019 mem_rvalid  input  1  load data valid; arrives no earlier than the cycle after mem_gnt.
REQ-020 mem_rdata  input  64  64-bit doubleword read from memory.

Function
REQ-021 FSM states: IDLE, REQ, WAIT, RESP.
REQ-022 IDLE: on req_valid, latch funct3, address, data and op type; go to REQ.
- With REQ-041 enabled, a misaligned request goes to RESP instead.
- A request with neither MemRead nor MemWrite goes directly to RESP as a no-op.
REQ-023 REQ: mem_req high; all mem_* fields stay stable until mem_gnt.
- Store with mem_gnt: go to RESP.
- Load with mem_gnt: go to WAIT.
REQ-024 WAIT: on mem_rvalid, register the extracted load result into ReadData and go to RESP; ignore mem_rdata otherwise.
REQ-025 RESP: resp_valid high for exactly one cycle, then go to IDLE; the next request can be accepted in the following cycle.
REQ-026 Lane selection: lane = addr[2:0].
- Store: mem_wdata = ReadData2 shifted left by 8*lane.
- Strobes: SB 0x01, SH 0x03, SW 0x0F, SD 0xFF, each shifted left by lane.
REQ-027 Load extraction: shift mem_rdata right by 8*lane, then take 8, 16, 32 or 64 bits.
- Sign-extend for LB, LH, LW; zero-extend for LBU, LHU, LWU.
REQ-028 Alignment rule: an access is misaligned when addr mod size != 0. funct3=111 is always treated as misaligned.
REQ-029 ReadData holds its last value when a store, a no-op or an error completes.
REQ-030 Minimum latency with mem_gnt held high (cycle 0 = acceptance in IDLE):
- Store: resp_valid in cycle 2.
- Load with mem_rvalid one cycle after mem_gnt: resp_valid in cycle 3.

Reset
REQ-031 While reset is low, all outputs and state take these values: state=IDLE, req_ready=0, resp_valid=0, misaligned=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, ReadData=0.
REQ-032 Reset asserted mid-transaction abandons the transaction.
- mem_req drops asynchronously.
- A mem_rvalid arriving after reset releases is ignored.
REQ-033 req_ready goes high in the first cycle after reset release.

Configuration
REQ-041 Macro LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned request issues no memory access; RESP is entered with misaligned=1.
- Undefined: misaligned is tied to 0; the access is issued on the doubleword containing the address, and any lanes that would overflow past byte 7 are dropped.

Verification
REQ-051 SD addr 0x10, data 0x1122334455667788, mem_gnt=1 -> mem_addr=0x10, wstrb=0xFF, resp_valid in cycle 2.
REQ-052 LB addr 0x23, mem_rdata 0x00000000_80000000 -> ReadData=0xFFFFFFFFFFFFFF80; LBU at the same address -> 0x80.
REQ-053 SH addr 0x06, data 0xABCD -> wstrb=0xC0, mem_wdata=0xABCD000000000000.
REQ-054 mem_gnt held low for 5 cycles -> mem_req and all mem_* fields stable; req_ready=0 throughout.
REQ-055 LW addr 0x02:
- with LSU_MISALIGN_TRAP_EN -> no mem_req, resp_valid with misaligned=1;
- without it -> access issued with wstrb=0, mem_addr=0x0.
REQ-056 reset driven low while in WAIT -> mem_req=0 and resp_valid=0 immediately; a stray mem_rvalid after release produces no resp_valid.
